alu_share_arbiter: RTL and testbench

//  Shares one ALU_DataPath instance between NREQ requesters (e.g. integer issue, address-gen, branch-compare).

---
 rtl/alu_share_arbiter_if.sv | 37 +++
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester, response and ALU-side signal bundle for alu_share_arbiter.
// slave = arbiter side, master = requesters/ALU/response-consumer side.
interface alu_share_arbiter_if #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 2
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ*N-1:0] REQ_IN0;
  logic [NREQ*N-1:0] REQ_IN1;
  logic [NREQ*3-1:0] REQ_FUNC3;
  logic [NREQ-1:0]   REQ_SUB;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [IDW-1:0]    RSP_ID;
  logic [N-1:0]      RSP_DATA;
  logic [N-1:0]      ALU_IN0;
  logic [N-1:0]      ALU_IN1;
  logic [2:0]        ALU_FUNC3;
  logic              ALU_SUB;
  logic              ALU_EN;
  logic [N-1:0]      ALU_OUT;

  modport slave (
    input  REQ_VALID, REQ_IN0, REQ_IN1, REQ_FUNC3, REQ_SUB, RSP_READY, ALU_OUT,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_DATA,
    output ALU_IN0, ALU_IN1, ALU_FUNC3, ALU_SUB, ALU_EN
  );

  modport master (
    output REQ_VALID, REQ_IN0, REQ_IN1, REQ_FUNC3, REQ_SUB, RSP_READY, ALU_OUT,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_DATA,
    input  ALU_IN0, ALU_IN1, ALU_FUNC3, ALU_SUB, ALU_EN
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters (IDLE -> EXEC -> RESP).
// Optional per-requester grant / conflict counters under `define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  alu_share_arbiter_if.slave   bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   STAT_GRANTS,
  output logic [15:0]          STAT_CONFLICT
`endif
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] win_idx, cand;
  logic           win_found, window, hs;

  logic [N-1:0]   op_in0_q, op_in1_q;
  logic [2:0]     op_func3_q;
  logic           op_sub_q;
  logic [IDW-1:0] op_id_q;

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [N-1:0]   rsp_data_q;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!win_found && bus.REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign window = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.RSP_READY);
  assign hs     = window && win_found;

  always_comb begin
    bus.REQ_READY = '0;
    if (hs) bus.REQ_READY = NREQ'(1) << win_idx;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.RSP_READY) state_d = hs ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_q <= IDW'(NREQ - 1);
      op_in0_q     <= '0;
      op_in1_q     <= '0;
      op_func3_q   <= '0;
      op_sub_q     <= 1'b0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      if (hs) begin
        op_in0_q     <= bus.REQ_IN0[win_idx*N +: N];
        op_in1_q     <= bus.REQ_IN1[win_idx*N +: N];
        op_func3_q   <= bus.REQ_FUNC3[win_idx*3 +: 3];
        op_sub_q     <= bus.REQ_SUB[win_idx];
        op_id_q      <= win_idx;
        last_grant_q <= win_idx;
      end
      if (state_q == ST_EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= bus.ALU_OUT;
        rsp_id_q    <= op_id_q;
      end else if ((state_q == ST_RESP) && bus.RSP_READY) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Operand regs only change on a handshake, so they also provide the hold value outside EXEC.
  assign bus.ALU_IN0   = op_in0_q;
  assign bus.ALU_IN1   = op_in1_q;
  assign bus.ALU_FUNC3 = op_func3_q;
  assign bus.ALU_SUB   = op_sub_q;
  assign bus.ALU_EN    = (state_q == ST_EXEC);
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_ID    = rsp_id_q;
  assign bus.RSP_DATA  = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grants_q [NREQ];
  logic [15:0] conflict_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NREQ; i++) grants_q[i] <= '0;
      conflict_q <= '0;
    end else if (hs) begin
      if (grants_q[win_idx] != '1) grants_q[win_idx] <= grants_q[win_idx] + 16'd1;
      if (($countones(bus.REQ_VALID) > 1) && (conflict_q != '1)) conflict_q <= conflict_q + 16'd1;
    end
  end

  always_comb begin
    STAT_GRANTS = '0;
    for (int unsigned i = 0; i < NREQ; i++) STAT_GRANTS[i*16 +: 16] = grants_q[i];
  end

  assign STAT_CONFLICT = conflict_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter with a reference RV32 ALU stub on ALU_*.
// Stats checks compile in when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;
  logic CLK;
  logic RST_N;
  int   n_vec = 0;
  int   n_err = 0;

  alu_share_arbiter_if #(.N(32), .NREQ(2)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [31:0] STAT_GRANTS;
  logic [15:0] STAT_CONFLICT;
`endif

  alu_share_arbiter #(.N(32), .NREQ(2)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .STAT_GRANTS  (STAT_GRANTS),
    .STAT_CONFLICT(STAT_CONFLICT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference ALU: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND
  always_comb begin
    case (bus.ALU_FUNC3)
      3'b000:  bus.ALU_OUT = bus.ALU_SUB ? bus.ALU_IN0 - bus.ALU_IN1 : bus.ALU_IN0 + bus.ALU_IN1;
      3'b001:  bus.ALU_OUT = bus.ALU_IN0 << bus.ALU_IN1[4:0];
      3'b010:  bus.ALU_OUT = {31'd0, $signed(bus.ALU_IN0) < $signed(bus.ALU_IN1)};
      3'b011:  bus.ALU_OUT = {31'd0, bus.ALU_IN0 < bus.ALU_IN1};
      3'b100:  bus.ALU_OUT = bus.ALU_IN0 ^ bus.ALU_IN1;
      3'b101:  bus.ALU_OUT = bus.ALU_SUB ? 32'($signed(bus.ALU_IN0) >>> bus.ALU_IN1[4:0])
                                          : bus.ALU_IN0 >> bus.ALU_IN1[4:0];
      3'b110:  bus.ALU_OUT = bus.ALU_IN0 | bus.ALU_IN1;
      default: bus.ALU_OUT = bus.ALU_IN0 & bus.ALU_IN1;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic sub);
    bus.REQ_IN0[i*32 +: 32] = a;
    bus.REQ_IN1[i*32 +: 32] = b;
    bus.REQ_FUNC3[i*3 +: 3] = f3;
    bus.REQ_SUB[i]          = sub;
  endtask

  task automatic reset_dut();
    bus.REQ_VALID = '0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  // Entered one step after an edge with the accept window open and RSP_READY=1.
  // Checks the grant, the EXEC cycle, and the response two cycles after the handshake cycle.
  task automatic xact(input string tag, input logic [1:0] vld, input int unsigned gid,
                      input logic [31:0] exp);
    logic [1:0] m;
    m = 2'b01 << gid;
    bus.REQ_VALID = vld;
    #1;
    check({tag, " grant"}, 64'(bus.REQ_READY), 64'(m));
    tick();
    bus.REQ_VALID = bus.REQ_VALID & ~m;
    #1;
    check({tag, " exec alu_en"}, 64'(bus.ALU_EN), 64'd1);
    check({tag, " exec rsp_valid"}, 64'(bus.RSP_VALID), 64'd0);
    check({tag, " exec req_ready"}, 64'(bus.REQ_READY), 64'd0);
    tick();
    check({tag, " rsp_valid"}, 64'(bus.RSP_VALID), 64'd1);
    check({tag, " rsp_id"}, 64'(bus.RSP_ID), 64'(gid));
    check({tag, " rsp_data"}, 64'(bus.RSP_DATA), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N         = 1'b0;
    bus.REQ_VALID = '0;
    bus.REQ_IN0   = '0;
    bus.REQ_IN1   = '0;
    bus.REQ_FUNC3 = '0;
    bus.REQ_SUB   = '0;
    bus.RSP_READY = 1'b0;

    #12;
    check("rst rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    check("rst rsp_id", 64'(bus.RSP_ID), 64'd0);
    check("rst rsp_data", 64'(bus.RSP_DATA), 64'd0);
    check("rst req_ready", 64'(bus.REQ_READY), 64'd0);
    check("rst alu_en", 64'(bus.ALU_EN), 64'd0);
    check("rst alu_in0", 64'(bus.ALU_IN0), 64'd0);
    check("rst alu_in1", 64'(bus.ALU_IN1), 64'd0);
    check("rst alu_func3", 64'(bus.ALU_FUNC3), 64'd0);
    check("rst alu_sub", 64'(bus.ALU_SUB), 64'd0);
    tick();
    RST_N = 1'b1;
    tick();

    // 1: single ADD 5+7
    set_req(0, 32'd5, 32'd7, 3'b000, 1'b0);
    bus.RSP_READY = 1'b1;
    xact("t1", 2'b01, 0, 32'd12);
    tick();
    check("t1 rsp_valid drop", 64'(bus.RSP_VALID), 64'd0);
    check("t1 idle req_ready", 64'(bus.REQ_READY), 64'd0);

    // 2: contended pairs after reset, req0 first then strict alternation
    reset_dut();
    set_req(0, 32'd10, 32'd3, 3'b000, 1'b1);
    set_req(1, 32'hF0, 32'hFF, 3'b100, 1'b0);
    xact("t2a", 2'b11, 0, 32'd7);
    xact("t2b", 2'b10, 1, 32'h0F);
    set_req(0, 32'd1, 32'd2, 3'b000, 1'b0);
    set_req(1, 32'hF0, 32'h3C, 3'b111, 1'b0);
    xact("t2c", 2'b11, 0, 32'd3);

    // 3: response back-pressure with both requesters waiting
    set_req(0, 32'd1, 32'd4, 3'b001, 1'b0);
    bus.RSP_READY = 1'b0;
    bus.REQ_VALID = 2'b11;
    #1;
    check("t3 stall req_ready", 64'(bus.REQ_READY), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3 stall rsp_valid", 64'(bus.RSP_VALID), 64'd1);
      check("t3 stall rsp_data", 64'(bus.RSP_DATA), 64'd3);
      check("t3 stall rsp_id", 64'(bus.RSP_ID), 64'd0);
      check("t3 stall req_ready", 64'(bus.REQ_READY), 64'd0);
      check("t3 stall alu_en", 64'(bus.ALU_EN), 64'd0);
    end
    bus.RSP_READY = 1'b1;
    xact("t3a", 2'b11, 1, 32'h30);
    xact("t3b", 2'b01, 0, 32'h10);

    // 4: req1 held valid, back-to-back SRA
    set_req(1, 32'h8000_0000, 32'd4, 3'b101, 1'b1);
    bus.REQ_VALID = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4 grant", 64'(bus.REQ_READY), 64'h2);
      check("t4 window alu_en", 64'(bus.ALU_EN), 64'd0);
      tick();
      check("t4 exec alu_en", 64'(bus.ALU_EN), 64'd1);
      check("t4 exec rsp_valid", 64'(bus.RSP_VALID), 64'd0);
      tick();
      check("t4 rsp_valid", 64'(bus.RSP_VALID), 64'd1);
      check("t4 rsp_data", 64'(bus.RSP_DATA), 64'hF800_0000);
      check("t4 rsp_id", 64'(bus.RSP_ID), 64'd1);
    end
    bus.REQ_VALID = '0;
    tick();
    check("t4 idle rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    check("t4 idle alu_en", 64'(bus.ALU_EN), 64'd0);
    check("t4 hold alu_in0", 64'(bus.ALU_IN0), 64'h8000_0000);
    check("t4 hold alu_func3", 64'(bus.ALU_FUNC3), 64'd5);

    // 5: reset asserted during EXEC
    set_req(0, 32'd2, 32'd2, 3'b000, 1'b0);
    bus.REQ_VALID = 2'b01;
    tick();
    bus.REQ_VALID = '0;
    check("t5 exec alu_en", 64'(bus.ALU_EN), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("t5 rst alu_en", 64'(bus.ALU_EN), 64'd0);
    check("t5 rst rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    check("t5 rst alu_in0", 64'(bus.ALU_IN0), 64'd0);
    tick();
    #4;
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t5 no stale rsp", 64'(bus.RSP_VALID), 64'd0);
      tick();
    end
    set_req(1, 32'd9, 32'd9, 3'b000, 1'b0);
    xact("t5a", 2'b11, 0, 32'd4);
    xact("t5b", 2'b10, 1, 32'd18);

`ifdef ALU_ARB_STATS_EN
    // 6: three solo req0 ops, then two contended pairs
    reset_dut();
    check("t6 rst grants", 64'(STAT_GRANTS), 64'd0);
    check("t6 rst conflict", 64'(STAT_CONFLICT), 64'd0);
    set_req(0, 32'd1, 32'd1, 3'b000, 1'b0);
    set_req(1, 32'd3, 32'd3, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) xact("t6 solo", 2'b01, 0, 32'd2);
    for (int i = 0; i < 2; i++) begin
      xact("t6 pair first", 2'b11, 1, 32'd6);
      xact("t6 pair second", 2'b01, 0, 32'd2);
    end
    bus.REQ_VALID = '0;
    tick();
    check("t6 grants0", 64'(STAT_GRANTS[15:0]), 64'd5);
    check("t6 grants1", 64'(STAT_GRANTS[31:16]), 64'd2);
    check("t6 conflict", 64'(STAT_CONFLICT), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
